// File: rtl/wmem_seq_pkg.sv
// Shared types for the hidden-layer weight-memory sequencer: FSM states,
// index-width helpers and the buffered stream beat.
package wmem_seq_pkg;

    // A 1-entry space still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WT_DATA_W   = 16;
    localparam int WT_N_IN     = 8;
    localparam int WT_N_HIDDEN = 4;
    localparam int WT_H_W      = idx_w(WT_N_HIDDEN);
    localparam int WT_I_W      = idx_w(WT_N_IN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } wmem_seq_state_t;

    typedef struct packed {
        logic signed [WT_DATA_W-1:0] data;
        logic [WT_H_W-1:0]           h;
        logic [WT_I_W-1:0]           i;
        logic                        last_i;
        logic                        last;
    } wt_beat_t;

endpackage

// File: rtl/wmem_rd_skid.sv
// Two-entry FIFO that catches read returns so the stream keeps one beat per
// cycle across the memory's read latency.
module wmem_rd_skid
    import wmem_seq_pkg::*;
#(
    parameter type T = wt_beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  T           push_data_i,
    input  logic       pop_i,
    output T           head_o,
    output logic [1:0] occ_o
);

    T           mem_q [2];
    logic       wp_q;
    logic       rp_q;
    logic [1:0] occ_q;

    // The issuer never pushes into a full buffer, so no full guard is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= push_data_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) rp_q <= ~rp_q;
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o = mem_q[rp_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/wmem_hidden_seq.sv
// Owns both ports of the hidden weight memory: host loads while idle, then a
// hidden-major weight stream to the neuron datapath over valid/ready.
module wmem_hidden_seq
    import wmem_seq_pkg::*;
#(
    parameter int DATA_W   = WT_DATA_W,
    parameter int N_IN     = WT_N_IN,
    parameter int N_HIDDEN = WT_N_HIDDEN,
    parameter int ADDR_H_W = idx_w(N_HIDDEN),
    parameter int ADDR_I_W = idx_w(N_IN),
    parameter int RADDR_W  = idx_w(N_HIDDEN * N_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_H_W-1:0]      ld_h,
    input  logic [ADDR_I_W-1:0]      ld_i,
    input  logic signed [DATA_W-1:0] ld_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     w_wr_en,
    output logic [ADDR_H_W-1:0]      w_addr_h,
    output logic [ADDR_I_W-1:0]      w_addr_i,
    output logic signed [DATA_W-1:0] w_data,
    output logic [RADDR_W-1:0]       raddr,
    input  logic signed [DATA_W-1:0] rdata,
    output logic                     wt_valid,
    input  logic                     wt_ready,
    output logic signed [DATA_W-1:0] wt_data,
    output logic [ADDR_H_W-1:0]      wt_h,
    output logic [ADDR_I_W-1:0]      wt_i,
    output logic                     wt_last_i,
    output logic                     wt_last
);

    wmem_seq_state_t     state_q, state_d;
    logic                settle_q, settle_d;
    logic [RADDR_W-1:0]  rc_q, rc_d;
    logic [ADDR_H_W-1:0] hc_q, hc_d;
    logic [ADDR_I_W-1:0] ic_q, ic_d;
    logic                rd_all_q, rd_all_d;

    logic                infl_q;
    logic [ADDR_H_W-1:0] infl_h_q;
    logic [ADDR_I_W-1:0] infl_i_q;
    logic                infl_li_q;
    logic                infl_l_q;

    wt_beat_t            push_beat;
    wt_beat_t            head;
    logic [1:0]          occ;
    logic [1:0]          fill;
    logic                pop;
    logic                rd_en;
    logic                rd_last_i;
    logic                rd_last;
    logic                wr_ok;

    // Host write port passes straight through, but only while idle.
    assign wr_ok    = (state_q == IDLE) && ld_valid;
    assign ld_ready = (state_q == IDLE);
    assign w_wr_en  = wr_ok;
    assign w_addr_h = wr_ok ? ld_h    : '0;
    assign w_addr_i = wr_ok ? ld_i    : '0;
    assign w_data   = wr_ok ? ld_data : '0;

    assign busy  = (state_q == SETTLE) || (state_q == STREAM);
    assign done  = (state_q == DONE);
    assign raddr = rc_q;

    // Entries already committed after this cycle's pop; issue only if one slot remains.
    assign pop       = wt_valid && wt_ready;
    assign fill      = occ + {1'b0, infl_q} - {1'b0, pop};
    assign rd_en     = (state_q == STREAM) && !rd_all_q && (fill < 2'd2);
    assign rd_last_i = (ic_q == ADDR_I_W'(N_IN - 1));
    assign rd_last   = rd_last_i && (hc_q == ADDR_H_W'(N_HIDDEN - 1));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        rc_d     = rc_q;
        hc_d     = hc_q;
        ic_d     = ic_q;
        rd_all_d = rd_all_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    settle_d = 1'b0;
                    rc_d     = '0;
                    hc_d     = '0;
                    ic_d     = '0;
                    rd_all_d = 1'b0;
                end
            end
            SETTLE: begin
                settle_d = ~settle_q;
                if (settle_q) state_d = STREAM;
            end
            STREAM: begin
                if (pop && head.last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Tags advance as counters alongside the read address.
        if (rd_en) begin
            rd_all_d = rd_last;
            if (!rd_last) rc_d = rc_q + 1'b1;
            if (rd_last_i) begin
                ic_d = '0;
                if (!rd_last) hc_d = hc_q + 1'b1;
            end else begin
                ic_d = ic_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            settle_q  <= 1'b0;
            rc_q      <= '0;
            hc_q      <= '0;
            ic_q      <= '0;
            rd_all_q  <= 1'b0;
            infl_q    <= 1'b0;
            infl_h_q  <= '0;
            infl_i_q  <= '0;
            infl_li_q <= 1'b0;
            infl_l_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            rc_q     <= rc_d;
            hc_q     <= hc_d;
            ic_q     <= ic_d;
            rd_all_q <= rd_all_d;
            infl_q   <= rd_en;
            if (rd_en) begin
                infl_h_q  <= hc_q;
                infl_i_q  <= ic_q;
                infl_li_q <= rd_last_i;
                infl_l_q  <= rd_last;
            end
        end
    end

    always_comb begin
        push_beat        = '0;
        push_beat.data   = rdata;
        push_beat.h      = infl_h_q;
        push_beat.i      = infl_i_q;
        push_beat.last_i = infl_li_q;
        push_beat.last   = infl_l_q;
    end

    wmem_rd_skid #(.T(wt_beat_t)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (infl_q),
        .push_data_i(push_beat),
        .pop_i      (pop),
        .head_o     (head),
        .occ_o      (occ)
    );

    // Stale entries stay hidden so an empty buffer drives zeros.
    assign wt_valid  = (occ != 2'd0);
    assign wt_data   = wt_valid ? head.data              : '0;
    assign wt_h      = wt_valid ? ADDR_H_W'(head.h)      : '0;
    assign wt_i      = wt_valid ? ADDR_I_W'(head.i)      : '0;
    assign wt_last_i = wt_valid && head.last_i;
    assign wt_last   = wt_valid && head.last;

endmodule

// File: tb/tb_wmem_hidden_seq.sv
// Directed bench for wmem_hidden_seq with a behavioural weight memory
// (registered write pipe, 1-cycle synchronous read).
module tb_wmem_hidden_seq;

    localparam int DATA_W   = 16;
    localparam int N_IN     = 8;
    localparam int N_HIDDEN = 4;
    localparam int NW       = N_IN * N_HIDDEN;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     ld_valid = 1'b0;
    logic                     ld_ready;
    logic [1:0]               ld_h = '0;
    logic [2:0]               ld_i = '0;
    logic signed [DATA_W-1:0] ld_data = '0;
    logic                     start = 1'b0;
    logic                     busy;
    logic                     done;
    logic                     w_wr_en;
    logic [1:0]               w_addr_h;
    logic [2:0]               w_addr_i;
    logic signed [DATA_W-1:0] w_data;
    logic [4:0]               raddr;
    logic signed [DATA_W-1:0] rdata = '0;
    logic                     wt_valid;
    logic                     wt_ready = 1'b0;
    logic signed [DATA_W-1:0] wt_data;
    logic [1:0]               wt_h;
    logic [2:0]               wt_i;
    logic                     wt_last_i;
    logic                     wt_last;

    int          n_chk = 0;
    int          n_pass = 0;
    int          occ_err = 0;
    int          dc;
    logic [15:0] mem     [NW];
    logic [15:0] exp_mem [NW];
    logic [22:0] bq [$];
    int          cq [$];
    logic [22:0] cur;
    logic        wr_q = 1'b0;
    logic [4:0]  wa_q = '0;
    logic [15:0] wd_q = '0;

    wmem_hidden_seq #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_h(ld_h), .ld_i(ld_i), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .w_wr_en(w_wr_en), .w_addr_h(w_addr_h), .w_addr_i(w_addr_i), .w_data(w_data),
        .raddr(raddr), .rdata(rdata),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data), .wt_h(wt_h), .wt_i(wt_i),
        .wt_last_i(wt_last_i), .wt_last(wt_last)
    );

    always #5 clk = ~clk;

    // Memory: write data lands one cycle after the write request.
    always @(posedge clk) begin
        wr_q  <= w_wr_en;
        wa_q  <= {w_addr_h, w_addr_i};
        wd_q  <= w_data;
        if (wr_q) mem[wa_q] <= wd_q;
        rdata <= mem[raddr];
    end

    assign cur = {wt_data, wt_h, wt_i, wt_last_i, wt_last};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int h, input int i, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_h     = h[1:0];
        ld_i     = i[2:0];
        ld_data  = d;
        exp_mem[h * N_IN + i] = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic chk_reset;
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_ctl", 32'({busy, done, w_wr_en, wt_valid, wt_last_i, wt_last}), 32'd0);
        chk("rst_w", 32'({w_addr_h, w_addr_i, w_data}), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_wt", 32'({wt_data, wt_h, wt_i}), 32'd0);
    endtask

    // Called at posedge+1 of cycle 0; returns at the negedge of the exit cycle.
    task automatic run_stream(input bit rnd, input int stop_at, input bit poke, output int done_cyc);
        bit          stl;
        logic [22:0] prev;
        bq.delete();
        cq.delete();
        done_cyc = -1;
        stl      = 1'b0;
        prev     = '0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        for (int c = 1; c < 1000; c++) begin
            wt_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            if (poke && c == 12) begin
                ld_valid = 1'b1; ld_h = 2'd0; ld_i = 3'd0; ld_data = 16'h7FFF; start = 1'b1;
            end
            @(negedge clk);
            if (c <= 2) chk("settle_busy", 32'({wt_valid, busy}), 32'd1);
            if (poke && c == 12) begin
                chk("blk_ld_ready", 32'(ld_ready), 32'd0);
                chk("blk_wr_en", 32'(w_wr_en), 32'd0);
            end
            if (stl) chk("stall_hold", 32'({wt_valid, cur}), 32'({1'b1, prev}));
            if (dut.u_skid.occ_o > 2'd2) occ_err++;
            stl  = wt_valid && !wt_ready;
            prev = cur;
            if (wt_valid && wt_ready) begin
                bq.push_back(cur);
                cq.push_back(c);
            end
            if (done) begin
                done_cyc = c;
                chk("done_busy", 32'(busy), 32'd0);
                break;
            end
            if (stop_at != 0 && bq.size() == stop_at) break;
            tick();
            ld_valid = 1'b0;
            start    = 1'b0;
        end
        if (done_cyc < 0 && stop_at == 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_beats(input bit cyc_chk);
        logic [22:0] e;
        chk("beat_count", 32'(bq.size()), 32'd32);
        for (int k = 0; k < bq.size() && k < NW; k++) begin
            e = {exp_mem[k], 2'(k / N_IN), 3'(k % N_IN), 1'(k % N_IN == N_IN - 1), 1'(k == NW - 1)};
            chk("beat", 32'(bq[k]), 32'(e));
            if (cyc_chk) chk("beat_cyc", 32'(cq[k]), 32'(5 + k));
        end
    endtask

    initial begin
        for (int k = 0; k < NW; k++) begin
            mem[k]     = '0;
            exp_mem[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Full stream of h*10+i+1
        for (int h = 0; h < N_HIDDEN; h++)
            for (int i = 0; i < N_IN; i++)
                load(h, i, 16'(h * 10 + i + 1));
        tick();
        run_stream(1'b0, 0, 1'b0, dc);
        chk("done_cyc", 32'(dc), 32'd37);
        check_beats(1'b1);
        tick();
        @(negedge clk);
        chk("done_pulse", 32'({done, busy, ld_ready}), 32'd1);
        tick();

        // Load in the same cycle as start
        ld_valid = 1'b1; ld_h = 2'd2; ld_i = 3'd3; ld_data = 16'hFE0C;
        exp_mem[19] = 16'hFE0C;
        run_stream(1'b0, 0, 1'b0, dc);
        check_beats(1'b1);
        if (bq.size() > 19) chk("beat19", 32'(bq[19][22:7]), 32'h0000FE0C);
        tick();

        // Random backpressure
        run_stream(1'b1, 0, 1'b0, dc);
        chk("bp_done", 32'(dc > 0), 32'd1);
        check_beats(1'b0);
        tick();

        // Load and start while streaming are both ignored
        run_stream(1'b0, 0, 1'b1, dc);
        check_beats(1'b1);
        tick();
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("start_ignored", 32'(busy), 32'd0);
            tick();
        end
        run_stream(1'b0, 0, 1'b0, dc);
        check_beats(1'b1);
        if (bq.size() > 0) chk("no_overwrite", 32'(bq[0][22:7]), 32'd1);
        tick();

        // Reset after ten beats
        run_stream(1'b0, 10, 1'b0, dc);
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        run_stream(1'b0, 0, 1'b0, dc);
        chk("rst_done_cyc", 32'(dc), 32'd37);
        check_beats(1'b1);

        chk("occ_max", 32'(occ_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
